// File: rtl/cfg_frame_writer.sv
// Frame-latch configuration writer: turns a synchronised 32-bit word stream into
// full frames of FrameData and a timed one-hot FrameStrobe into the addressed column/frame.
module cfg_frame_writer #(
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumberOfRows    = 4,
    parameter int unsigned NumberOfCols    = 4,
    parameter int unsigned StrobeWidth     = 2,
    parameter logic [FrameBitsPerRow-1:0] SyncWord   = 32'hFAB0_FAB1,
    parameter logic [FrameBitsPerRow-1:0] DesyncWord = 32'hFAB0_FAB0
) (
    input  logic                                       CLK,
    input  logic                                       resetn,
    input  logic [FrameBitsPerRow-1:0]                 s_data,
    input  logic                                       s_valid,
    output logic                                       s_ready,
    output logic [FrameBitsPerRow*NumberOfRows-1:0]    FrameData,
    output logic [MaxFramesPerCol*NumberOfCols-1:0]    FrameStrobe,
    output logic                                       frame_done,
    output logic                                       err_hdr,
    output logic                                       synced
);

    localparam int unsigned FD_W  = FrameBitsPerRow * NumberOfRows;
    localparam int unsigned FS_W  = MaxFramesPerCol * NumberOfCols;
    localparam int unsigned ROW_W = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam int unsigned COL_W = (NumberOfCols > 1) ? $clog2(NumberOfCols) : 1;
    localparam int unsigned FRM_W = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam int unsigned IDX_W = (FS_W > 1) ? $clog2(FS_W) : 1;
    localparam int unsigned STB_W = 4;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        HEADER = 3'd1,
        DATA   = 3'd2,
        SETUP  = 3'd3,
        STROBE = 3'd4,
        HOLD   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [FRM_W-1:0]   frm_q, frm_d;
    logic [FD_W-1:0]    frame_data_q, frame_data_d;
    logic [FS_W-1:0]    strobe_q, strobe_d;
    logic               s_ready_q, s_ready_d;
    logic               frame_done_q, frame_done_d;
    logic               err_q, err_d;
    logic               synced_q, synced_d;

    logic               accept_c;
    logic               hdr_ok_c;
    logic [IDX_W-1:0]   strb_idx_c;

    // Header: [31:28] tag, [15:8] column, [4:0] frame; other bits are don't-care
    always_comb begin
        accept_c   = s_valid && s_ready_q;
        hdr_ok_c   = (s_data[31:28] == 4'hA)
                  && (32'(s_data[15:8]) < NumberOfCols)
                  && (32'(s_data[4:0]) < MaxFramesPerCol);
        strb_idx_c = IDX_W'(col_q) * IDX_W'(MaxFramesPerCol) + IDX_W'(frm_q);
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        stb_cnt_d    = stb_cnt_q;
        col_d        = col_q;
        frm_d        = frm_q;
        frame_data_d = frame_data_q;
        err_d        = err_q;
        synced_d     = synced_q;

        case (state_q)
            HUNT: begin
                if (accept_c && (s_data == SyncWord)) begin
                    state_d  = HEADER;
                    synced_d = 1'b1;
                    err_d    = 1'b0;
                end
            end
            HEADER: begin
                if (accept_c) begin
                    if (s_data == DesyncWord) begin
                        state_d  = HUNT;
                        synced_d = 1'b0;
                    end else if (hdr_ok_c) begin
                        col_d   = COL_W'(s_data[15:8]);
                        frm_d   = FRM_W'(s_data[4:0]);
                        row_d   = '0;
                        state_d = DATA;
                    end else begin
                        err_d    = 1'b1;
                        synced_d = 1'b0;
                        state_d  = HUNT;
                    end
                end
            end
            DATA: begin
                if (accept_c) begin
                    frame_data_d[row_q*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
                    if (row_q == ROW_W'(NumberOfRows - 1)) begin
                        row_d   = '0;
                        state_d = SETUP;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            SETUP: begin
                stb_cnt_d = '0;
                state_d   = STROBE;
            end
            STROBE: begin
                if (stb_cnt_q == STB_W'(StrobeWidth - 1)) begin
                    stb_cnt_d = '0;
                    state_d   = HOLD;
                end else begin
                    stb_cnt_d = stb_cnt_q + STB_W'(1);
                end
            end
            HOLD: begin
                state_d = HEADER;
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        s_ready_d    = (state_d == HUNT) || (state_d == HEADER) || (state_d == DATA);
        frame_done_d = (state_d == HOLD);
        strobe_d     = '0;
        if (state_d == STROBE) begin
            strobe_d[strb_idx_c] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q      <= HUNT;
            row_q        <= '0;
            stb_cnt_q    <= '0;
            col_q        <= '0;
            frm_q        <= '0;
            frame_data_q <= '0;
            strobe_q     <= '0;
            s_ready_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            synced_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            stb_cnt_q    <= stb_cnt_d;
            col_q        <= col_d;
            frm_q        <= frm_d;
            frame_data_q <= frame_data_d;
            strobe_q     <= strobe_d;
            s_ready_q    <= s_ready_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            synced_q     <= synced_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign FrameData   = frame_data_q;
    assign FrameStrobe = strobe_q;
    assign frame_done  = frame_done_q;
    assign err_hdr     = err_q;
    assign synced      = synced_q;

endmodule

// File: tb/tb_cfg_frame_writer.sv
// Randomised scoreboard bench for cfg_frame_writer: a word-level reference model
// predicts frames and flags; a separate monitor checks strobes and frame_done.
module tb_cfg_frame_writer;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;
    localparam int unsigned MFPC = 20;
    localparam int unsigned SW   = 2;
    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [127:0]  FrameData;
    logic [79:0]   FrameStrobe;
    logic          frame_done;
    logic          err_hdr;
    logic          synced;

    cfg_frame_writer #(
        .FrameBitsPerRow (32),
        .MaxFramesPerCol (MFPC),
        .NumberOfRows    (ROWS),
        .NumberOfCols    (COLS),
        .StrobeWidth     (SW),
        .SyncWord        (SYNC),
        .DesyncWord      (DESYNC)
    ) dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .frame_done  (frame_done),
        .err_hdr     (err_hdr),
        .synced      (synced)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit gap_en = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int           idx;
        logic [127:0] fd;
        int           acc;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: what the writer should look like after the coming edge
    localparam int M_HUNT = 0, M_HDR = 1, M_DATA = 2;
    int           m_mode  = M_HUNT;
    bit           m_sync  = 1'b0;
    bit           m_err   = 1'b0;
    bit           m_ready = 1'b0;
    int           m_busy  = 0;
    int           m_words = 0;
    int           m_idx   = 0;
    logic [127:0] m_fd    = '0;

    always @(negedge CLK) begin
        chk("s_ready",   256'(s_ready),   256'(m_ready));
        chk("synced",    256'(synced),    256'(m_sync));
        chk("err_hdr",   256'(err_hdr),   256'(m_err));
        chk("FrameData", 256'(FrameData), 256'(m_fd));
        if (!resetn) begin
            m_mode = M_HUNT; m_sync = 0; m_err = 0; m_ready = 0;
            m_busy = 0; m_words = 0; m_fd = '0;
            exp_q.delete();
        end else begin
            if (m_busy > 0) m_busy--;
            if (s_valid && m_ready) begin
                case (m_mode)
                    M_HUNT: if (s_data == SYNC) begin
                        m_mode = M_HDR; m_sync = 1; m_err = 0;
                    end
                    M_HDR: begin
                        if (s_data == DESYNC) begin
                            m_mode = M_HUNT; m_sync = 0;
                        end else if (s_data[31:28] == 4'hA && int'(s_data[15:8]) < COLS
                                     && int'(s_data[4:0]) < MFPC) begin
                            m_idx   = int'(s_data[15:8]) * MFPC + int'(s_data[4:0]);
                            m_words = 0;
                            m_mode  = M_DATA;
                        end else begin
                            m_err = 1; m_sync = 0; m_mode = M_HUNT;
                        end
                    end
                    default: begin
                        m_fd[m_words*32 +: 32] = s_data;
                        m_words++;
                        if (m_words == ROWS) begin
                            exp_q.push_back('{idx: m_idx, fd: m_fd, acc: cyc + 1});
                            m_busy = 2 + SW;
                            m_mode = M_HDR;
                        end
                    end
                endcase
            end
            m_ready = (m_busy == 0);
        end
    end

    // Monitor: strobe placement, width, latency and frame_done against the queue
    bit   rst_prev = 1'b0;
    bit   in_run   = 1'b0;
    bit   have_cur = 1'b0;
    int   run_len  = 0;
    exp_t cur;

    always @(negedge CLK) begin
        if (!rst_prev) begin
            chk("strobe_in_reset", 256'(FrameStrobe), 256'(0));
            chk("done_in_reset",   256'(frame_done),  256'(0));
            in_run = 0; have_cur = 0;
        end else begin
            if (FrameStrobe != '0) begin
                chk("strobe_onehot", 256'($onehot(FrameStrobe)), 256'(1));
                if (!in_run) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", 256'(FrameStrobe), 256'(0));
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1;
                        chk("strobe_bit",     256'(FrameStrobe), 256'(1) << cur.idx);
                        chk("strobe_data",    256'(FrameData),   256'(cur.fd));
                        chk("strobe_latency", 256'(cyc - cur.acc), 256'(1));
                    end
                    in_run = 1; run_len = 1;
                end else begin
                    run_len++;
                    if (have_cur) chk("strobe_hold", 256'(FrameStrobe), 256'(1) << cur.idx);
                end
            end else if (in_run) begin
                chk("strobe_width", 256'(run_len), 256'(SW));
                in_run = 0;
            end
            if (have_cur && cyc == cur.acc + 3) begin
                chk("frame_done",      256'(frame_done), 256'(1));
                chk("done_data_held",  256'(FrameData),  256'(cur.fd));
                have_cur = 0;
            end else if (frame_done) begin
                chk("unexpected_done", 256'(frame_done), 256'(0));
            end
        end
        rst_prev = resetn;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic send(input logic [31:0] w);
        int   t;
        logic r;
        if (gap_en) begin
            while ($urandom_range(0, 1) == 1) begin
                s_valid = 1'b0; s_data = $urandom; tick(1);
            end
        end
        s_data = w; s_valid = 1'b1; t = 0;
        forever begin
            r = s_ready;
            tick(1);
            if (r) break;
            t++;
            if (t > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: word %08h not accepted, s_ready %0b expected 1", w, s_ready);
                break;
            end
        end
        s_valid = 1'b0; s_data = $urandom;
    endtask

    function automatic logic [31:0] mk_hdr(input int col, input int frm);
        logic [31:0] h;
        h = $urandom;
        h[31:28] = 4'hA;
        h[15:8]  = 8'(col);
        h[4:0]   = 5'(frm);
        return h;
    endfunction

    task automatic frame(input logic [31:0] hdr);
        send(hdr);
        for (int i = 0; i < ROWS; i++) send($urandom);
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0; tick(n); resetn = 1'b1;
    endtask

    logic [31:0] w;
    int          k;

    initial begin
        tick(2);
        resetn = 1'b1;
        tick(2);

        // Pre-sync words are discarded, then a directed frame to column 2 frame 5
        send(32'h1234_5678); send(32'hA000_0000); tick(3);
        send(SYNC);
        send(32'hA000_0205);
        send(32'h1111_1111); send(32'h2222_2222);
        send(32'h3333_3333); send(32'h4444_4444);
        tick(8);
        chk("frame1_data", 256'(FrameData), 256'(128'h44444444_33333333_22222222_11111111));

        // Back-to-back frames at the strobe extremes, then desync
        frame(32'hA000_0000);
        frame(32'hA000_0313);
        send(DESYNC);
        tick(8);

        // Bad column and bad tag; trailing words must be ignored until resync
        send(SYNC); send(32'hA000_0415);
        for (int i = 0; i < ROWS; i++) send($urandom);
        send(SYNC); send(32'hB000_0001);
        for (int i = 0; i < ROWS; i++) send($urandom);
        send(SYNC); tick(3);

        // Same traffic with 50% s_valid gaps
        gap_en = 1'b1;
        frame(32'hA000_0205);
        for (int i = 0; i < 4; i++) frame(mk_hdr($urandom_range(0, COLS-1), $urandom_range(0, MFPC-1)));
        gap_en = 1'b0;

        // Reset during the second strobe cycle, then recover
        frame(mk_hdr(1, 7));
        tick(2);
        do_reset(2);
        tick(2);
        send(SYNC);
        frame(mk_hdr(3, 2));
        tick(8);

        // Random soak over every word class
        gap_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 99);
            if (k < 10)      w = SYNC;
            else if (k < 14) w = DESYNC;
            else if (k < 40) w = mk_hdr($urandom_range(0, COLS-1), $urandom_range(0, MFPC-1));
            else if (k < 48) w = mk_hdr($urandom_range(COLS, 255), $urandom_range(0, 31));
            else if (k < 52) w = mk_hdr($urandom_range(0, COLS-1), $urandom_range(MFPC, 31));
            else             w = $urandom;
            send(w);
        end
        gap_en = 1'b0;
        tick(10);

        chk("queue_drained",  256'(exp_q.size()), 256'(0));
        chk("no_open_frame",  256'(have_cur),     256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
